store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Circular FIFO of committed stores between the MEM-stage pipeline register and the data cache.
//  Accepts one store per cycle from the MEM/WB flipflop outputs and drains one store per mem_ack.
//  Provides same-cycle store-to-load forwarding lookup for the MEM stage.
//  A full buffer or an unforwardable match stalls the pipeline via the hazard unit.
// PARAMETERS
//  DEPTH       4   entries; power of two, >=2
//  ADDR_WIDTH  32  byte-address width
//  DATA_WIDTH  32  store data width (word = 4 bytes)
// PORTS
//  clk              in   1           clock, rising edge
//  reset            in   1           asynchronous, active-high; clears all state
//  push_valid       in   1           store request from MEM stage
//  push_byte        in   1           1 = byte store (data[7:0] at addr[1:0]); 0 = word store
//  push_addr        in   ADDR_WIDTH  store byte address
//  push_data        in   DATA_WIDTH  store data
//  full             out  1           count == DEPTH; push rejected
//  empty            out  1           count == 0
//  mem_req          out  1           head entry valid (== !empty)
//  mem_byte         out  1           head entry byte flag
//  mem_addr         out  ADDR_WIDTH  head entry address
//  mem_data         out  DATA_WIDTH  head entry data
//  mem_ack          in   1           cache accepted head entry this cycle
//  lookup_addr      in   ADDR_WIDTH  word-load address from MEM stage
//  lookup_hit       out  1           youngest matching entry is a word store; forward lookup_data
//  lookup_data      out  DATA_WIDTH  data of that entry (0 when !lookup_hit)
//  lookup_conflict  out  1           youngest matching entry is a byte store; load must stall
// BEHAVIOUR
//  - State: DEPTH entries {byte,addr,data}, head/tail ptrs (log2 DEPTH bits, wrap mod DEPTH), count (log2 DEPTH+1 bits).
//  - Reset (async): head=tail=count=0, entries zeroed; full=0, empty=1, mem_req=0, mem_*=0,
//    lookup_hit=0, lookup_conflict=0, lookup_data=0.
//  - Push: push_valid && !full -> entry[tail] written at clk edge, tail++. push_valid && full -> ignored
//    (no state change); the hazard unit must hold the store upstream.
//  - Full is evaluated on start-of-cycle count: a pop in the same cycle does NOT free a slot for that push.
//  - Pop: mem_req && mem_ack -> head++ at clk edge. mem_ack while empty is ignored.
//  - Push and pop in the same cycle (not full, not empty): both occur, count unchanged.
//  - count: +1 on push only, -1 on pop only; never exceeds DEPTH, never below 0.
//  - Latency: a pushed store appears on mem_* in the cycle after its push (1 cycle), or later if not at head.
//  - mem_* are driven directly from entry[head]; stable while mem_req=1 and no mem_ack.
//  - Drain order is strict FIFO; stores are never merged or reordered.
//  - Lookup (combinational): match = valid entry with addr[ADDR_WIDTH-1:2] == lookup_addr[ADDR_WIDTH-1:2].
//    Youngest matching entry (closest to tail) wins. Word store -> hit=1, data=entry data.
//    Byte store -> conflict=1, hit=0. No match -> hit=0, conflict=0.
//  - Lookup sees start-of-cycle contents: a same-cycle push is not visible; an entry popped this cycle still is.
//  - hit and conflict are never both 1.
//  - Reset mid-operation discards all pending stores; no mem_req after reset until a new push.
// TESTING
//  1. Reset then push word {0x100,0xDEADBEEF}, mem_ack=0 -> next cycle mem_req=1, mem_addr=0x100, mem_data=0xDEADBEEF, empty=0.
//  2. Push 4 stores, no ack -> full=1; 5th push ignored; ack x4 drains in push order, then empty=1, mem_req=0.
//  3. Full buffer, push_valid and mem_ack same cycle -> pop only; count 4->3, pushed store not stored.
//  4. Words 0x200=0x11, then 0x200=0x22 buffered; lookup 0x200 -> hit=1, data=0x22. Lookup 0x204 -> hit=0, conflict=0.
//  5. Word 0x300 then byte 0x302 buffered; lookup 0x300 -> conflict=1, hit=0, data=0.
//  6. 3 entries buffered, assert reset mid-cycle -> empty=1, full=0, mem_req=0 immediately; lookup of old addr -> hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: a circular FIFO of committed stores waiting for the data cache.
// It also offers same-cycle store-to-load forwarding for word loads in the MEM stage.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic                  push_byte,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  empty,
    output logic                  mem_req,
    output logic                  mem_byte,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ack,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_WIDTH-1:0] lookup_data,
    output logic                  lookup_conflict
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                  ent_byte [DEPTH];
    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push_en;
    logic pop_en;

    logic [PTR_W-1:0] scan_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign mem_req = !empty;

    // Full is judged on the start-of-cycle count, so a same-cycle pop never admits a push.
    assign push_en = push_valid && !full;
    assign pop_en  = mem_req && mem_ack;

    // Stale head contents are hidden once the buffer drains.
    assign mem_byte = mem_req ? ent_byte[head] : 1'b0;
    assign mem_addr = mem_req ? ent_addr[head] : '0;
    assign mem_data = mem_req ? ent_data[head] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_byte[i] <= 1'b0;
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (push_en) begin
                ent_byte[tail] <= push_byte;
                ent_addr[tail] <= push_addr;
                ent_data[tail] <= push_data;
                tail           <= tail + 1'b1;
            end
            if (pop_en) begin
                head <= head + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match found is the one nearest the tail.
    always_comb begin
        lookup_hit      = 1'b0;
        lookup_conflict = 1'b0;
        lookup_data     = '0;
        scan_idx        = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (ent_addr[scan_idx][ADDR_WIDTH-1:2] == lookup_addr[ADDR_WIDTH-1:2])) begin
                lookup_hit      = !ent_byte[scan_idx];
                lookup_conflict = ent_byte[scan_idx];
                lookup_data     = ent_byte[scan_idx] ? '0 : ent_data[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the buffered stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic        push_byte;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic        full;
    logic        empty;
    logic        mem_req;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        lookup_conflict;

    typedef struct packed {
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
    } store_t;

    store_t q[$];
    int     tests;
    int     fails;

    store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_byte       (push_byte),
        .push_addr       (push_addr),
        .push_data       (push_data),
        .full            (full),
        .empty           (empty),
        .mem_req         (mem_req),
        .mem_byte        (mem_byte),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_ack         (mem_ack),
        .lookup_addr     (lookup_addr),
        .lookup_hit      (lookup_hit),
        .lookup_data     (lookup_data),
        .lookup_conflict (lookup_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest matching store decides: word forwards, byte forces a stall.
    task automatic model_lookup(input logic [31:0] la, output logic h, output logic c,
                                output logic [31:0] d);
        h = 1'b0;
        c = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == la[31:2]) begin
                h = !q[i].b;
                c = q[i].b;
                d = q[i].b ? 32'h0 : q[i].d;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        h;
        logic        c;
        logic [31:0] d;
        model_lookup(lookup_addr, h, c, d);
        chk({tag, ".full"},  {31'b0, full},    {31'b0, q.size() == DEPTH});
        chk({tag, ".empty"}, {31'b0, empty},   {31'b0, q.size() == 0});
        chk({tag, ".req"},   {31'b0, mem_req}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk({tag, ".mbyte"}, {31'b0, mem_byte}, {31'b0, q[0].b});
            chk({tag, ".maddr"}, mem_addr, q[0].a);
            chk({tag, ".mdata"}, mem_data, q[0].d);
        end
        chk({tag, ".hit"},  {31'b0, lookup_hit},      {31'b0, h});
        chk({tag, ".conf"}, {31'b0, lookup_conflict}, {31'b0, c});
        chk({tag, ".ldata"}, lookup_data, d);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic applyStimulus(input string tag, input logic pv, input logic pb,
                                 input logic [31:0] pa, input logic [31:0] pd,
                                 input logic ack, input logic [31:0] la);
        logic push_ok;
        logic pop_ok;
        push_valid  = pv;
        push_byte   = pb;
        push_addr   = pa;
        push_data   = pd;
        mem_ack     = ack;
        lookup_addr = la;
        #1;
        check_outputs(tag);
        push_ok = pv && (q.size() < DEPTH);
        pop_ok  = ack && (q.size() > 0);
        @(posedge clk);
        if (pop_ok) q.delete(0);
        if (push_ok) q.push_back('{pb, pa, pd});
        @(negedge clk);
        push_valid = 1'b0;
        mem_ack    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] la, input logic eh,
                               input logic ec, input logic [31:0] ed);
        lookup_addr = la;
        #1;
        chk({tag, ".hit"},  {31'b0, lookup_hit},      {31'b0, eh});
        chk({tag, ".conf"}, {31'b0, lookup_conflict}, {31'b0, ec});
        chk({tag, ".ldata"}, lookup_data, ed);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        push_valid  = 1'b0;
        push_byte   = 1'b0;
        push_addr   = '0;
        push_data   = '0;
        mem_ack     = 1'b0;
        lookup_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.empty", {31'b0, empty},   32'd1);
        chk("rst.full",  {31'b0, full},    32'd0);
        chk("rst.req",   {31'b0, mem_req}, 32'd0);
        chk("rst.maddr", mem_addr, 32'h0);
        chk("rst.mdata", mem_data, 32'h0);
        chk("rst.hit",   {31'b0, lookup_hit}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // First store becomes visible on mem_* one cycle after its push.
        applyStimulus("s1.push", 1, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        #1;
        chk("s1.req",   {31'b0, mem_req}, 32'd1);
        chk("s1.maddr", mem_addr, 32'h100);
        chk("s1.mdata", mem_data, 32'hDEADBEEF);
        applyStimulus("s1.drain", 0, 0, 0, 0, 1, 32'h100);

        for (int i = 0; i < 4; i++)
            applyStimulus("s2.fill", 1, 0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 0, 32'h10);
        applyStimulus("s2.over", 1, 0, 32'h80, 32'hBAD, 0, 32'h80);
        #1;
        chk("s2.full", {31'b0, full}, 32'd1);
        applyStimulus("s3.pushpop", 1, 0, 32'h90, 32'hBAD2, 1, 32'h90);
        #1;
        chk("s3.full",  {31'b0, full}, 32'd0);
        chk("s3.maddr", mem_addr, 32'h14);
        for (int i = 0; i < 3; i++)
            applyStimulus("s2.drain", 0, 0, 0, 0, 1, 32'h1C);
        #1;
        chk("s2.empty", {31'b0, empty},   32'd1);
        chk("s2.req",   {31'b0, mem_req}, 32'd0);

        applyStimulus("s4.w1", 1, 0, 32'h200, 32'h11, 0, 32'h200);
        applyStimulus("s4.w2", 1, 0, 32'h200, 32'h22, 0, 32'h200);
        checkOutput("s4.same", 32'h200, 1, 0, 32'h22);
        checkOutput("s4.other", 32'h204, 0, 0, 32'h0);
        applyStimulus("s4.d1", 0, 0, 0, 0, 1, 32'h200);
        applyStimulus("s4.d2", 0, 0, 0, 0, 1, 32'h200);

        applyStimulus("s5.word", 1, 0, 32'h300, 32'h12345678, 0, 32'h300);
        applyStimulus("s5.byte", 1, 1, 32'h302, 32'hAB, 0, 32'h300);
        checkOutput("s5.conf", 32'h300, 0, 1, 32'h0);
        applyStimulus("s6.third", 1, 0, 32'h400, 32'h44, 0, 32'h400);

        // Reset asserted in the middle of a cycle takes effect without a clock edge.
        lookup_addr = 32'h400;
        #3;
        reset = 1'b1;
        q.delete();
        #1;
        chk("s6.empty", {31'b0, empty},   32'd1);
        chk("s6.full",  {31'b0, full},    32'd0);
        chk("s6.req",   {31'b0, mem_req}, 32'd0);
        chk("s6.hit",   {31'b0, lookup_hit}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("s6.idle", 0, 0, 0, 0, 0, 32'h300);

        for (int n = 0; n < 400; n++) begin
            applyStimulus("rnd",
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0),
                          32'h500 + 32'($urandom_range(0, 15)),
                          $urandom,
                          ($urandom_range(0, 2) == 0),
                          32'h500 + 32'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
